display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexes the four clock digits (HH:MM) onto a single shared `displaydecoder` instance and drives the common digit enables of the 4-digit 7-segment display. Each clock, the block presents one BCD nibble to the decoder and enables exactly one digit, with anti-ghosting guard time. Digit data is snapshotted once per frame so the display never tears. It also provides per-digit blanking, blinking for set mode, hour-tens leading-zero suppression and the colon drive.

## Interface
- `SCAN_DIV`, 50000 — clock cycles per digit slot; legal range ≥ 2.
- `GUARD`, 2 — cycles at the start of each slot with all digits off; legal range 1 ≤ GUARD < SCAN_DIV.
- `BLINK_DIV`, 128 — frames per blink half-period; legal range ≥ 1.
- `clk  in  1` — the single system clock.
- `reset_n  in  1` — asynchronous, active-low reset.
- `digits_in  in  16` — digit nibbles: [3:0] minutes ones, [7:4] minutes tens, [11:8] hours ones, [15:12] hours tens.
- `blank_mask  in  4` — bit i = 1 forces digit i off.
- `blink_mask  in  4` — bit i = 1 turns digit i off during the blink-off phase.
- `lz_blank  in  1` — 1: turn digit 3 off when its snapshotted value is 0.
- `colon_blink  in  1` — 1: colon follows the blink phase; 0: colon steady on.
- `bcd_out  out  4` — nibble to the shared decoder's `bcd_in`.
- `digit_en_n  out  4` — active-low digit enables; at most one bit is low.
- `colon_out  out  1` — colon segment, active-high.
- `frame_tick  out  1` — one-cycle pulse at each frame boundary.

## Operation
- State: `slot_cnt` (0..SCAN_DIV-1), `idx` (2 bits), `frame_cnt` (0..BLINK_DIV-1), `blink_ph`, `load_pend`.
- Shadow registers: `sh_digits`, `sh_blank`, `sh_blink`, `sh_lz`, `sh_cb`.
- Scan: `slot_cnt` increments every cycle.
  - At SCAN_DIV-1 it wraps to 0 and `idx` advances 0→1→2→3→0.
- Frame boundary (`slot_cnt`=SCAN_DIV-1 and `idx`=3), all in the same edge:
  - shadow registers load from the inputs;
  - `frame_tick` is set for the next cycle;
  - `frame_cnt` increments.
- Blink phase: when `frame_cnt` is at BLINK_DIV-1 at a frame boundary, it wraps to 0 and `blink_ph` toggles.
- `load_pend`: reset to 1. It forces a shadow load on the first clock after reset release, then clears to 0.
- Inputs outside the frame boundary (and the post-reset load) are ignored; no tearing within a frame.
- `bcd_out` = `sh_digits` nibble selected by `idx`.
  - Values 10–15 pass through unchanged; the decoder shows a dash.
- `digit_en_n[idx]` = 0 only when all of these hold:
  - `slot_cnt` ≥ GUARD;
  - `sh_blank[idx]` = 0;
  - not (`sh_blink[idx]` and `blink_ph`);
  - not (`idx`=3 and `sh_lz` and `sh_digits[15:12]`=0).
- All other `digit_en_n` bits are 1.
- `colon_out` = `~blink_ph` when `sh_cb` = 1, else 1.
- All outputs are decoded from registered state only; no input-to-output combinational path.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - `slot_cnt`=0, `idx`=0, `frame_cnt`=0, `blink_ph`=0, `load_pend`=1;
  - shadows = 0, except `sh_blank`=4'b1111.
  - Outputs: `bcd_out`=0, `digit_en_n`=4'b1111, `colon_out`=1, `frame_tick`=0.
- Reset asserted mid-slot or mid-frame: immediate return to reset values; no partial digit stays lit.
- First release edge: shadows load, and scanning of digit 0 begins. Digit 0 first lights at cycle GUARD after release.
- Slot period = SCAN_DIV cycles; frame period = 4·SCAN_DIV cycles.
- Blink half-period = BLINK_DIV frames.
- Changing `idx` and setting `digit_en_n` to all-off happen on the same edge: no overlap between digits.
- Input change → visible effect: at the next frame boundary, at most 4·SCAN_DIV cycles.
- `frame_tick` is high for exactly one cycle, in the first cycle of digit 0's slot.

## Test plan
Bench uses SCAN_DIV=4, GUARD=1, BLINK_DIV=2.
- Reset, then `digits_in`=16'h1234, masks 0.
  - Slot sequence `bcd_out` = 4,3,2,1.
  - `digit_en_n` = 1111 in slot cycle 0, then 1110/1101/1011/0111 in cycles 1–3.
  - `frame_tick` every 16 cycles.
- Change `digits_in` to 16'h0959 mid-frame: the current frame still shows 1234; the next frame shows 9,5,9,0.
- `lz_blank`=1 with 16'h0959: digit 3 stays 1111 through its whole slot. Same test with 16'h1959: digit 3 lights.
- `blink_mask`=4'b0011, `colon_blink`=1:
  - digits 0 and 1 are dark in frames 2–3, lit in frames 0–1 and 4–5;
  - `colon_out` = 1,1,0,0,1,1 per frame.
- `blank_mask`=4'b1111: `digit_en_n` stays 1111 for a whole frame while `bcd_out` still cycles through the digits.
- Assert `reset_n`=0 in slot cycle 2 of digit 2: outputs go to reset values immediately; after release, scanning restarts at digit 0.

Source files
------------

// File: rtl/display_scan_controller.sv
// display_scan_controller
//
// Time-multiplexes the four HH:MM digits onto one shared BCD-to-7-segment
// decoder. Each digit gets a slot of SCAN_DIV cycles. The first GUARD cycles
// of every slot keep all digits dark so the previous digit cannot ghost into
// the next one. Digit data and display controls are snapshotted into shadow
// registers once per frame, so a frame never shows a mix of old and new data.
//
// Parameters:
//   SCAN_DIV  - cycles per digit slot (>= 2)
//   GUARD     - dark cycles at the start of each slot (1 <= GUARD < SCAN_DIV)
//   BLINK_DIV - frames per blink half-period (>= 1)
//
// Ports:
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   digits_in    - {hours tens, hours ones, minutes tens, minutes ones}
//   blank_mask   - per-digit force-off
//   blink_mask   - per-digit off during the blink-off phase
//   lz_blank     - suppress the hours-tens digit when it is zero
//   colon_blink  - colon follows the blink phase (else steady on)
//   bcd_out      - nibble for the shared decoder
//   digit_en_n   - active-low digit enables, at most one low
//   colon_out    - colon segment, active-high
//   frame_tick   - one-cycle pulse in the first cycle of digit 0's slot
module display_scan_controller #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 2,
  parameter int BLINK_DIV = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic        lz_blank,
  input  logic        colon_blink,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_en_n,
  output logic        colon_out,
  output logic        frame_tick
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(BLINK_DIV + 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_GUARD = SW'(GUARD);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic          load_pend_q, load_pend_d;
  logic          frame_tick_q, frame_tick_d;
  logic [15:0]   sh_digits_q, sh_digits_d;
  logic [3:0]    sh_blank_q, sh_blank_d;
  logic [3:0]    sh_blink_q, sh_blink_d;
  logic          sh_lz_q, sh_lz_d;
  logic          sh_cb_q, sh_cb_d;

  logic slot_last;
  logic frame_end;
  logic load;

  always_comb begin
    slot_last    = (slot_cnt_q == SLOT_LAST);
    frame_end    = slot_last && (idx_q == 2'd3);
    // The post-reset load fills the shadows before the first frame is shown.
    load         = frame_end || load_pend_q;

    slot_cnt_d   = slot_last ? '0 : slot_cnt_q + SW'(1);
    idx_d        = slot_last ? idx_q + 2'd1 : idx_q;
    frame_tick_d = frame_end;
    load_pend_d  = 1'b0;

    frame_cnt_d  = frame_cnt_q;
    blink_ph_d   = blink_ph_q;
    if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    sh_digits_d = sh_digits_q;
    sh_blank_d  = sh_blank_q;
    sh_blink_d  = sh_blink_q;
    sh_lz_d     = sh_lz_q;
    sh_cb_d     = sh_cb_q;
    if (load) begin
      sh_digits_d = digits_in;
      sh_blank_d  = blank_mask;
      sh_blink_d  = blink_mask;
      sh_lz_d     = lz_blank;
      sh_cb_d     = colon_blink;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_q   <= '0;
      idx_q        <= 2'd0;
      frame_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      load_pend_q  <= 1'b1;
      frame_tick_q <= 1'b0;
      sh_digits_q  <= 16'h0000;
      // All digits blanked until the first shadow load.
      sh_blank_q   <= 4'b1111;
      sh_blink_q   <= 4'b0000;
      sh_lz_q      <= 1'b0;
      sh_cb_q      <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_ph_q   <= blink_ph_d;
      load_pend_q  <= load_pend_d;
      frame_tick_q <= frame_tick_d;
      sh_digits_q  <= sh_digits_d;
      sh_blank_q   <= sh_blank_d;
      sh_blink_q   <= sh_blink_d;
      sh_lz_q      <= sh_lz_d;
      sh_cb_q      <= sh_cb_d;
    end
  end

  logic lz_off;
  logic lit;

  // Outputs decode registered state only. Because idx and slot_cnt change on
  // the same edge and slot 0 is always inside the guard window, the old digit
  // turns off on exactly the edge the new nibble appears.
  always_comb begin
    case (idx_q)
      2'd0:    bcd_out = sh_digits_q[3:0];
      2'd1:    bcd_out = sh_digits_q[7:4];
      2'd2:    bcd_out = sh_digits_q[11:8];
      default: bcd_out = sh_digits_q[15:12];
    endcase

    lz_off = (idx_q == 2'd3) && sh_lz_q && (sh_digits_q[15:12] == 4'd0);
    lit    = (slot_cnt_q >= SLOT_GUARD) && !sh_blank_q[idx_q] &&
             !(sh_blink_q[idx_q] && blink_ph_q) && !lz_off;

    digit_en_n = 4'b1111;
    if (lit) digit_en_n[idx_q] = 1'b0;

    colon_out  = sh_cb_q ? ~blink_ph_q : 1'b1;
    frame_tick = frame_tick_q;
  end

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int S  = 4;
  localparam int G  = 1;
  localparam int B  = 2;
  localparam int FR = 4 * S;

  logic        clk;
  logic        reset_n;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        lz_blank;
  logic        colon_blink;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en_n;
  logic        colon_out;
  logic        frame_tick;

  display_scan_controller #(.SCAN_DIV(S), .GUARD(G), .BLINK_DIV(B)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .digits_in   (digits_in),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .lz_blank    (lz_blank),
    .colon_blink (colon_blink),
    .bcd_out     (bcd_out),
    .digit_en_n  (digit_en_n),
    .colon_out   (colon_out),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: time since reset release in cycles, plus the input
  // snapshot taken at the first edge and at the last cycle of every frame.
  int          n;
  logic [15:0] m_dig;
  logic [3:0]  m_bl, m_bk;
  logic        m_lz, m_cb;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n     = 0;
      m_dig = 16'h0000;
      m_bl  = 4'b1111;
      m_bk  = 4'b0000;
      m_lz  = 1'b0;
      m_cb  = 1'b0;
    end else begin
      if (n == 0 || (n % FR) == FR - 1) begin
        m_dig = digits_in;
        m_bl  = blank_mask;
        m_bk  = blink_mask;
        m_lz  = lz_blank;
        m_cb  = colon_blink;
      end
      n = n + 1;
    end
  end

  always @(negedge clk) begin
    int   slot, d;
    logic ph;
    logic [3:0] nib, en;
    slot = n % S;
    d    = (n / S) % 4;
    ph   = ((n / FR) / B) % 2 == 1;
    nib  = m_dig[d*4 +: 4];
    en   = 4'b1111;
    if (slot >= G && !m_bl[d] && !(m_bk[d] && ph) && !(d == 3 && m_lz && m_dig[15:12] == 4'd0))
      en[d] = 1'b0;
    chk("bcd_out", {12'h0, bcd_out}, {12'h0, nib});
    chk("digit_en_n", {12'h0, digit_en_n}, {12'h0, en});
    chk("colon_out", {15'h0, colon_out}, {15'h0, (m_cb ? !ph : 1'b1)});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, (n != 0 && n % FR == 0)});
    chk("one_hot_en", {15'h0, ($countones(~digit_en_n) <= 1)}, 16'h1);
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    bit hit;
    reset_n     = 1'b0;
    digits_in   = 16'h1234;
    blank_mask  = 4'b0000;
    blink_mask  = 4'b0000;
    lz_blank    = 1'b0;
    colon_blink = 1'b0;
    step(1);
    chk("reset_bcd", {12'h0, bcd_out}, 16'h0);
    chk("reset_en", {12'h0, digit_en_n}, 16'h000f);
    chk("reset_colon", {15'h0, colon_out}, 16'h1);
    chk("reset_tick", {15'h0, frame_tick}, 16'h0);
    do_reset();

    // Basic scan, then a mid-frame data change.
    step(40);
    digits_in = 16'h0959;
    step(40);
    lz_blank = 1'b1;
    step(36);
    digits_in = 16'h1959;
    step(36);

    // Blink from a fresh reset so frames are numbered from release.
    lz_blank    = 1'b0;
    blink_mask  = 4'b0011;
    colon_blink = 1'b1;
    do_reset();
    step(6 * FR + 4);

    blink_mask  = 4'b0000;
    colon_blink = 1'b0;
    blank_mask  = 4'b1111;
    step(2 * FR + 3);
    blank_mask  = 4'b0000;

    // Randomized inputs, changed at arbitrary points within frames.
    for (int i = 0; i < 30; i++) begin
      digits_in   = {4'($urandom_range(0, 2)), 12'($urandom)};
      blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      blink_mask  = 4'($urandom);
      lz_blank    = 1'($urandom);
      colon_blink = 1'($urandom);
      if ($urandom_range(0, 9) == 0) do_reset();
      step($urandom_range(1, 50));
    end

    // Reset asserted in slot cycle 2 of digit 2.
    digits_in  = 16'h4321;
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    lz_blank   = 1'b0;
    colon_blink = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 4 * FR; i++) begin
      @(posedge clk);
      #1;
      if (n % FR == 2 * S + 2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_digit2_slot2", {15'h0, hit}, 16'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_bcd", {12'h0, bcd_out}, 16'h0);
    chk("midreset_en", {12'h0, digit_en_n}, 16'h000f);
    chk("midreset_colon", {15'h0, colon_out}, 16'h1);
    chk("midreset_tick", {15'h0, frame_tick}, 16'h0);
    step(2);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_bcd_digit0", {12'h0, bcd_out}, 16'h0001);
    chk("restart_en_digit0", {12'h0, digit_en_n}, 16'h000e);
    step(FR + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
